gx400_palette_out: RTL and testbench

- Final colour stage of the GX400 video path.
- Takes the per-pixel palette index from the priority mixer and looks it up in a CPU-writable colour RAM.
- Applies active-window blanking and drives 15-bit xBGR555 video to the downstream video sink / frame dumper.
- Outputs delayed H/V counter copies so that data and counters arrive aligned downstream.

---
 rtl/gx400_palette_out.sv | 149 ++++++++++++++
 tb/tb_gx400_palette_out.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gx400_palette_out.sv
// GX400 final colour stage: palette lookup, window blanking and aligned H/V outputs, plus CPU palette port.
// Optional colour-bar override is built only when GX400_PAL_DEBUG_BARS_EN is defined.
module gx400_palette_out #(
  parameter int          PAL_AW      = 11,
  parameter logic [8:0]  H_ACT_START = 9'd278,
  parameter logic [8:0]  H_ACT_END   = 9'd149,
  parameter logic [8:0]  V_ACT_START = 9'd272,
  parameter logic [8:0]  V_ACT_END   = 9'd495
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_INITRST,
  input  logic              i_EMU_CLK6MPCEN_n,
  input  logic [8:0]        i_HCOUNTER,
  input  logic [8:0]        i_VCOUNTER,
  input  logic [PAL_AW-1:0] i_PIXEL_INDEX,
  input  logic [PAL_AW-1:0] i_CPU_ADDR,
  input  logic [15:0]       i_CPU_DIN,
  input  logic              i_CPU_CS_n,
  input  logic              i_CPU_RW,
  input  logic              i_CPU_UDS_n,
  input  logic              i_CPU_LDS_n,
  output logic [15:0]       o_CPU_DOUT,
  output logic              o_CPU_DTACK_n,
  input  logic              i_DEBUG_BARS,
  output logic [15:0]       o_VIDEODATA,
  output logic [8:0]        o_HCOUNTER,
  output logic [8:0]        o_VCOUNTER,
  output logic              o_BLANK
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} cpu_state_t;

  cpu_state_t        state;
  logic [15:0]       mem [0:(2**PAL_AW)-1];
  logic [15:0]       pix_q;
  logic [15:0]       pix_rgb;
  logic [8:0]        s1_h, s1_v;
  logic              s1_act;
  logic              pix_en;
  logic              h_act, v_act;
  logic [PAL_AW-1:0] cpu_addr;
  logic [15:0]       cpu_din;
  logic              cpu_rw, cpu_uds_n, cpu_lds_n;

  assign pix_en = ~i_EMU_CLK6MPCEN_n;

  // Horizontal window wraps: [H_ACT_START..511] followed by [128..H_ACT_END].
  always_comb begin
    h_act = (i_HCOUNTER >= H_ACT_START) ||
            ((i_HCOUNTER >= 9'd128) && (i_HCOUNTER <= H_ACT_END));
    v_act = (i_VCOUNTER >= V_ACT_START) && (i_VCOUNTER <= V_ACT_END);
  end

  // Both ports share one array; non-blocking update gives read-old-data on collisions.
  always_ff @(posedge i_EMU_MCLK) begin
    if (!i_EMU_INITRST && (state == ACCESS) && !cpu_rw) begin
      if (!cpu_uds_n) mem[cpu_addr][15:8] <= cpu_din[15:8];
      if (!cpu_lds_n) mem[cpu_addr][7:0]  <= cpu_din[7:0];
    end
    if (pix_en) pix_q <= mem[i_PIXEL_INDEX];
  end

`ifdef GX400_PAL_DEBUG_BARS_EN
  logic [8:0] bar_off;
  logic [2:0] s1_bar;
  logic       s1_dbg;

  assign bar_off = i_HCOUNTER - H_ACT_START;

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      s1_bar <= '0;
      s1_dbg <= 1'b0;
    end else if (pix_en) begin
      s1_bar <= bar_off[7:5];
      s1_dbg <= i_DEBUG_BARS;
    end
  end

  always_comb begin
    pix_rgb = {1'b0, pix_q[14:0]};
    if (s1_dbg) pix_rgb = {1'b0, {5{s1_bar[2]}}, {5{s1_bar[1]}}, {5{s1_bar[0]}}};
  end
`else
  logic unused_debug_bars;
  assign unused_debug_bars = i_DEBUG_BARS;

  always_comb pix_rgb = {1'b0, pix_q[14:0]};
`endif

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      s1_h        <= '0;
      s1_v        <= '0;
      s1_act      <= 1'b0;
      o_VIDEODATA <= '0;
      o_HCOUNTER  <= '0;
      o_VCOUNTER  <= '0;
      o_BLANK     <= 1'b1;
    end else if (pix_en) begin
      s1_h        <= i_HCOUNTER;
      s1_v        <= i_VCOUNTER;
      s1_act      <= h_act && v_act;
      o_VIDEODATA <= s1_act ? pix_rgb : '0;
      o_HCOUNTER  <= s1_h;
      o_VCOUNTER  <= s1_v;
      o_BLANK     <= ~s1_act;
    end
  end

  // Bus request is latched on entry to ACCESS so a long-held CS cannot re-write.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      state         <= IDLE;
      o_CPU_DTACK_n <= 1'b1;
      o_CPU_DOUT    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_CPU_CS_n && (!i_CPU_UDS_n || !i_CPU_LDS_n)) begin
            state     <= ACCESS;
            cpu_addr  <= i_CPU_ADDR;
            cpu_din   <= i_CPU_DIN;
            cpu_rw    <= i_CPU_RW;
            cpu_uds_n <= i_CPU_UDS_n;
            cpu_lds_n <= i_CPU_LDS_n;
          end
        end
        ACCESS: begin
          if (cpu_rw) o_CPU_DOUT <= mem[cpu_addr];
          if (!i_CPU_CS_n) begin
            state         <= ACK;
            o_CPU_DTACK_n <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        ACK: begin
          if (i_CPU_CS_n) begin
            state         <= IDLE;
            o_CPU_DTACK_n <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gx400_palette_out.sv
// Self-checking bench for gx400_palette_out: directed scenarios plus randomized traffic against a behavioural model.
module tb_gx400_palette_out;

`ifdef GX400_PAL_DEBUG_BARS_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en_n;
  logic [8:0]  hcnt, vcnt;
  logic [10:0] pix_index, cpu_addr;
  logic [15:0] cpu_din, dout, vdata;
  logic        cs_n, rw, uds_n, lds_n, dtack_n, dbg_bars, blank;
  logic [8:0]  hout, vout;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [8:0]  h;
    logic [8:0]  v;
    logic        b;
  } pix_t;

  localparam pix_t PIX_RST = '{d: 16'h0000, h: 9'd0, v: 9'd0, b: 1'b1};

  logic [15:0] model_mem [0:2047];
  pix_t        exp_o, pend;
  logic [10:0] valid_addr [0:15];

  gx400_palette_out dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_INITRST     (rst),
    .i_EMU_CLK6MPCEN_n (en_n),
    .i_HCOUNTER        (hcnt),
    .i_VCOUNTER        (vcnt),
    .i_PIXEL_INDEX     (pix_index),
    .i_CPU_ADDR        (cpu_addr),
    .i_CPU_DIN         (cpu_din),
    .i_CPU_CS_n        (cs_n),
    .i_CPU_RW          (rw),
    .i_CPU_UDS_n       (uds_n),
    .i_CPU_LDS_n       (lds_n),
    .o_CPU_DOUT        (dout),
    .o_CPU_DTACK_n     (dtack_n),
    .i_DEBUG_BARS      (dbg_bars),
    .o_VIDEODATA       (vdata),
    .o_HCOUNTER        (hout),
    .o_VCOUNTER        (vout),
    .o_BLANK           (blank)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  // Reference: expected output for a pixel presented at an enable, seen two enables later.
  function automatic pix_t calc(input logic [10:0] idx, input logic [8:0] h, input logic [8:0] v,
                                input logic dbg);
    pix_t r;
    bit   act;
    int   off, bar;
    act = ((h >= 278 && h <= 511) || (h >= 128 && h <= 149)) && (v >= 272 && v <= 495);
    r.h = h;
    r.v = v;
    r.b = !act;
    if (!act) r.d = 16'h0000;
    else if (DBG_EN && dbg) begin
      off = (int'(h) - 278 + 512) % 512;
      bar = (off / 32) % 8;
      r.d = 16'h0000;
      if (bar % 2 == 1)       r.d = r.d + 16'd31;
      if ((bar / 2) % 2 == 1) r.d = r.d + 16'd31 * 16'd32;
      if (bar / 4 == 1)       r.d = r.d + 16'd31 * 16'd1024;
    end else r.d = model_mem[idx] % 16'h8000;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix_step(input logic [10:0] idx, input logic [8:0] h, input logic [8:0] v,
                          input logic en, input logic dbg);
    pix_t nxt;
    nxt = calc(idx, h, v, dbg);
    pix_index = idx; hcnt = h; vcnt = v; dbg_bars = dbg; en_n = ~en;
    tick();
    if (en) begin
      exp_o = pend;
      pend  = nxt;
    end
    en_n = 1'b1;
  endtask

  task automatic cpu_access(input logic [10:0] a, input logic [15:0] d, input logic r,
                            input logic u, input logic l,
                            output logic [15:0] q, output bit ok, output int lat);
    ok = 1'b1;
    cpu_addr = a; cpu_din = d; rw = r; uds_n = ~u; lds_n = ~l; cs_n = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (dtack_n !== 1'b0 && lat < 10);
    if (dtack_n !== 1'b0) ok = 1'b0;
    q = dout;
    cs_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    tick();
    if (dtack_n !== 1'b1) ok = 1'b0;
    if (ok && !r) begin
      if (u) model_mem[a] = {d[15:8], model_mem[a][7:0]};
      if (l) model_mem[a] = {model_mem[a][15:8], d[7:0]};
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cs_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; en_n = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_o = PIX_RST;
    pend  = PIX_RST;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; en_n = 1'b1; rw = 1'b1;
    cpu_addr = '0; cpu_din = '0; pix_index = '0; hcnt = '0; vcnt = '0; dbg_bars = 1'b0;
    tick(); tick();
    total++; if (vdata !== 16'h0000) begin bad++; $display("FAIL rst_video got=%h exp=0000", vdata); end
    total++; if (blank !== 1'b1)     begin bad++; $display("FAIL rst_blank got=%b exp=1", blank); end
    total++; if (hout !== 9'd0)      begin bad++; $display("FAIL rst_hout got=%0d exp=0", hout); end
    total++; if (vout !== 9'd0)      begin bad++; $display("FAIL rst_vout got=%0d exp=0", vout); end
    total++; if (dout !== 16'h0000)  begin bad++; $display("FAIL rst_dout got=%h exp=0000", dout); end
    total++; if (dtack_n !== 1'b1)   begin bad++; $display("FAIL rst_dtack got=%b exp=1", dtack_n); end
    rst = 1'b0;
    exp_o = PIX_RST;
    pend  = PIX_RST;
    for (int i = 0; i < 10; i++) begin
      pix_step(11'h000, 9'd0, 9'd0, 1'b1, 1'b0);
      total++;
      if (vdata !== 16'h0000 || blank !== 1'b1 || dtack_n !== 1'b1) begin
        bad++;
        $display("FAIL idle_enables got=%h/%b/%b exp=0000/1/1", vdata, blank, dtack_n);
      end
    end
  endtask

  task automatic test_word_write();
    logic [15:0] q; bit ok; int lat;
    cpu_access(11'h005, 16'h7FFF, 1'b0, 1'b1, 1'b1, q, ok, lat);
    total++; if (!ok) begin bad++; $display("FAIL word_write_handshake got=%b exp=1", ok); end
    pix_step(11'h005, 9'd300, 9'd300, 1'b1, 1'b0);
    pix_step(11'h000, 9'd0, 9'd0, 1'b1, 1'b0);
    total++; if (vdata !== 16'h7FFF) begin bad++; $display("FAIL word_video got=%h exp=7fff", vdata); end
    total++; if (hout !== 9'd300)    begin bad++; $display("FAIL word_hout got=%0d exp=300", hout); end
    total++; if (vout !== 9'd300)    begin bad++; $display("FAIL word_vout got=%0d exp=300", vout); end
    total++; if (blank !== 1'b0)     begin bad++; $display("FAIL word_blank got=%b exp=0", blank); end
  endtask

  task automatic test_byte_write();
    logic [15:0] q; bit ok; int lat;
    cpu_access(11'h010, 16'h00AB, 1'b0, 1'b0, 1'b1, q, ok, lat);
    total++; if (!ok || lat != 2) begin bad++; $display("FAIL lds_write got=ok%b/lat%0d exp=ok1/lat2", ok, lat); end
    cpu_access(11'h010, 16'h1200, 1'b0, 1'b1, 1'b0, q, ok, lat);
    total++; if (!ok || lat != 2) begin bad++; $display("FAIL uds_write got=ok%b/lat%0d exp=ok1/lat2", ok, lat); end
    cpu_access(11'h010, 16'h0000, 1'b1, 1'b1, 1'b1, q, ok, lat);
    total++; if (!ok || lat != 2) begin bad++; $display("FAIL byte_read_hs got=ok%b/lat%0d exp=ok1/lat2", ok, lat); end
    total++; if (q !== 16'h12AB) begin bad++; $display("FAIL byte_read got=%h exp=12ab", q); end
  endtask

  task automatic test_window();
    logic [15:0] q; bit ok; int lat;
    logic [8:0]  hs [0:7] = '{9'd277, 9'd150, 9'd511, 9'd128, 9'd300, 9'd300, 9'd300, 9'd300};
    logic [8:0]  vs [0:7] = '{9'd300, 9'd300, 9'd300, 9'd300, 9'd271, 9'd272, 9'd495, 9'd496};
    bit          on [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    cpu_access(11'h020, 16'hC321, 1'b0, 1'b1, 1'b1, q, ok, lat);
    total++; if (!ok) begin bad++; $display("FAIL window_write got=%b exp=1", ok); end
    for (int i = 0; i < 8; i++) begin
      pix_step(11'h020, hs[i], vs[i], 1'b1, 1'b0);
      pix_step(11'h000, 9'd0, 9'd0, 1'b1, 1'b0);
      total++;
      if (vdata !== (on[i] ? 16'h4321 : 16'h0000) || blank !== !on[i] || hout !== hs[i] || vout !== vs[i]) begin
        bad++;
        $display("FAIL window h=%0d v=%0d got=%h/%b/%0d/%0d exp=%h/%b", hs[i], vs[i], vdata, blank,
                 hout, vout, on[i] ? 16'h4321 : 16'h0000, !on[i]);
      end
    end
  endtask

  task automatic test_collision();
    logic [15:0] q; bit ok; int lat;
    cpu_access(11'h040, 16'h0AAA, 1'b0, 1'b1, 1'b1, q, ok, lat);
    total++; if (!ok) begin bad++; $display("FAIL coll_preset got=%b exp=1", ok); end
    cpu_addr = 11'h040; cpu_din = 16'h0BBB; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; cs_n = 1'b0;
    tick();
    pix_step(11'h040, 9'd300, 9'd300, 1'b1, 1'b0);
    tick();
    total++; if (dtack_n !== 1'b0) begin bad++; $display("FAIL coll_dtack got=%b exp=0", dtack_n); end
    cs_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    tick();
    model_mem[11'h040] = 16'h0BBB;
    pix_step(11'h000, 9'd0, 9'd0, 1'b1, 1'b0);
    total++; if (vdata !== 16'h0AAA) begin bad++; $display("FAIL coll_old got=%h exp=0aaa", vdata); end
    pix_step(11'h040, 9'd300, 9'd300, 1'b1, 1'b0);
    pix_step(11'h000, 9'd0, 9'd0, 1'b1, 1'b0);
    total++; if (vdata !== 16'h0BBB) begin bad++; $display("FAIL coll_new got=%h exp=0bbb", vdata); end
  endtask

  task automatic test_long_cs();
    logic [15:0] q; bit ok; int lat; int n; int lowcnt;
    cpu_access(11'h030, 16'h0000, 1'b0, 1'b1, 1'b1, q, ok, lat);
    total++; if (!ok) begin bad++; $display("FAIL long_preset got=%b exp=1", ok); end
    cpu_addr = 11'h030; cpu_din = 16'h1234; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; cs_n = 1'b0;
    n = 0;
    do begin tick(); n++; end while (dtack_n !== 1'b0 && n < 10);
    total++; if (dtack_n !== 1'b0 || n != 2) begin bad++; $display("FAIL long_ack got=%b/lat%0d exp=0/lat2", dtack_n, n); end
    cpu_din = 16'h5678;
    lowcnt = 0;
    repeat (18) begin tick(); if (dtack_n === 1'b0) lowcnt++; end
    total++; if (lowcnt != 18) begin bad++; $display("FAIL long_hold got=%0d exp=18", lowcnt); end
    cs_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    tick();
    total++; if (dtack_n !== 1'b1) begin bad++; $display("FAIL long_release got=%b exp=1", dtack_n); end
    model_mem[11'h030] = 16'h1234;
    cpu_access(11'h030, 16'h0000, 1'b1, 1'b1, 1'b1, q, ok, lat);
    total++; if (!ok || q !== 16'h1234) begin bad++; $display("FAIL long_readback got=%h exp=1234", q); end
  endtask

  task automatic test_reset_mid_cycle();
    logic [15:0] q; bit ok; int lat; int n;
    cpu_access(11'h032, 16'h1111, 1'b0, 1'b1, 1'b1, q, ok, lat);
    total++; if (!ok) begin bad++; $display("FAIL rmid_preset got=%b exp=1", ok); end
    cpu_addr = 11'h031; cpu_din = 16'h0555; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; cs_n = 1'b0;
    n = 0;
    do begin tick(); n++; end while (dtack_n !== 1'b0 && n < 10);
    total++; if (dtack_n !== 1'b0) begin bad++; $display("FAIL rack_enter got=%b exp=0", dtack_n); end
    rst = 1'b1;
    tick();
    total++; if (dtack_n !== 1'b1) begin bad++; $display("FAIL rack_release got=%b exp=1", dtack_n); end
    rst = 1'b0; cs_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    exp_o = PIX_RST; pend = PIX_RST;
    tick();
    model_mem[11'h031] = 16'h0555;
    cpu_addr = 11'h032; cpu_din = 16'h2222; uds_n = 1'b0; lds_n = 1'b0; cs_n = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; cs_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    tick();
    cpu_access(11'h032, 16'h0000, 1'b1, 1'b1, 1'b1, q, ok, lat);
    total++; if (!ok || q !== 16'h1111) begin bad++; $display("FAIL racc_dropped got=%h exp=1111", q); end
    cpu_access(11'h031, 16'h0000, 1'b1, 1'b1, 1'b1, q, ok, lat);
    total++; if (!ok || q !== 16'h0555) begin bad++; $display("FAIL rack_kept got=%h exp=0555", q); end
  endtask

  task automatic test_random();
    logic [15:0] q; bit ok; int lat;
    logic [8:0]  hb [0:6] = '{9'd128, 9'd149, 9'd150, 9'd277, 9'd278, 9'd511, 9'd300};
    logic [8:0]  vb [0:3] = '{9'd271, 9'd272, 9'd495, 9'd496};
    logic [8:0]  h, v;
    for (int i = 0; i < 16; i++) begin
      valid_addr[i] = 11'($urandom_range(0, 2047));
      cpu_access(valid_addr[i], 16'($urandom), 1'b0, 1'b1, 1'b1, q, ok, lat);
      total++; if (!ok) begin bad++; $display("FAIL rnd_init_write got=%b exp=1", ok); end
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        lat = $urandom_range(1, 3);
        cpu_access(valid_addr[$urandom_range(0, 15)], 16'($urandom), 1'b0, lat[1], lat[0], q, ok, lat);
        total++; if (!ok) begin bad++; $display("FAIL rnd_write got=%b exp=1", ok); end
      end else begin
        h = ($urandom_range(0, 2) == 0) ? hb[$urandom_range(0, 6)] : 9'($urandom_range(128, 511));
        v = ($urandom_range(0, 2) == 0) ? vb[$urandom_range(0, 3)] : 9'($urandom_range(256, 511));
        pix_step(valid_addr[$urandom_range(0, 15)], h, v, $urandom_range(0, 9) < 7, 1'($urandom));
      end
      total++;
      if (vdata !== exp_o.d || hout !== exp_o.h || vout !== exp_o.v || blank !== exp_o.b) begin
        bad++;
        $display("FAIL rnd_pixel it=%0d got=%h/%0d/%0d/%b exp=%h/%0d/%0d/%b", i, vdata, hout, vout,
                 blank, exp_o.d, exp_o.h, exp_o.v, exp_o.b);
      end
    end
  endtask

`ifdef GX400_PAL_DEBUG_BARS_EN
  task automatic test_debug_bars();
    logic [8:0]  hs [0:2] = '{9'd278, 9'd310, 9'd502};
    logic [15:0] ex [0:2] = '{16'h0000, 16'h001F, 16'h7FFF};
    for (int i = 0; i < 3; i++) begin
      pix_step(11'h005, hs[i], 9'd300, 1'b1, 1'b1);
      pix_step(11'h000, 9'd0, 9'd0, 1'b1, 1'b0);
      total++;
      if (vdata !== ex[i] || blank !== 1'b0) begin
        bad++;
        $display("FAIL bars h=%0d got=%h/%b exp=%h/0", hs[i], vdata, blank, ex[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word_write();
    test_byte_write();
    test_window();
    test_collision();
    test_long_cs();
    test_reset_mid_cycle();
`ifdef GX400_PAL_DEBUG_BARS_EN
    test_debug_bars();
`endif
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
